// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the single-issue MIPS datapath blocks.
//   BUBBLE_INSTR  - word loaded into IF/ID when it must carry no instruction;
//                   its opcode (all ones) decodes to "no control asserted".
//   OP_*          - opcode values the controller and fetch stage agree on.
//   *_MSB / *_LSB - bit positions of the instruction fields.
package mips_pkg;

    localparam logic [31:0] BUBBLE_INSTR = 32'hFC00_0000;

    localparam logic [5:0] OP_RTYPE  = 6'b000000;
    localparam logic [5:0] OP_LW     = 6'b100011;
    localparam logic [5:0] OP_SW     = 6'b101011;
    localparam logic [5:0] OP_BUBBLE = 6'b111111;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

endpackage

// File: rtl/instr_mem.sv
// instr_mem: word-addressed instruction memory, 2^AW x 32.
//   CLK    in  - clock; writes land on the rising edge
//   we     in  - write enable (program load)
//   waddr  in  - write word address
//   wdata  in  - write data
//   raddr  in  - read word address
//   rdata  out - read data, combinational from raddr
// The read is asynchronous, so a register sampling rdata on the same edge
// as a write to that word captures the old contents (read-before-write).
// Contents are deliberately not reset.
module instr_mem #(
    parameter int AW = 8
) (
    input  logic          CLK,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<AW)-1];

    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: program counter, instruction fetch and IF/ID register.
//   CLK, reset            - clock and synchronous active-high reset
//   stall                 - hold PC and IF/ID
//   redirect, redirect_pc - load a new word-aligned PC and squash IF/ID
//   imem_we/waddr/wdata   - instruction memory write port (program load)
//   pc                    - current fetch PC
//   id_valid, id_pc, id_pc4, id_instr - IF/ID register contents
//   opcode, rs, rt, rd, shamt, funct, imm - fields sliced from id_instr
// Edge priority: reset > redirect > stall > advance. A squashed or reset
// IF/ID holds BUBBLE_INSTR so downstream control decodes to all-zero.
module instr_fetch_stage
    import mips_pkg::*;
#(
    parameter int          IMEM_AW  = 8,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               CLK,
    input  logic               reset,
    input  logic               stall,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               imem_we,
    input  logic [IMEM_AW-1:0] imem_waddr,
    input  logic [31:0]        imem_wdata,
    output logic [31:0]        pc,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [31:0]        id_pc4,
    output logic [31:0]        id_instr,
    output logic [5:0]         opcode,
    output logic [4:0]         rs,
    output logic [4:0]         rt,
    output logic [4:0]         rd,
    output logic [4:0]         shamt,
    output logic [5:0]         funct,
    output logic [15:0]        imm
);

    logic [31:0] pc_q, pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] fetch_word;
    logic [31:0] pc_plus4;

    // Only the low word-address bits index the memory, so PCs past the
    // array depth alias back onto it.
    instr_mem #(
        .AW (IMEM_AW)
    ) u_imem (
        .CLK   (CLK),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata),
        .raddr (pc_q[IMEM_AW+1:2]),
        .rdata (fetch_word)
    );

    // Modulo-2^32 increment: 32'hFFFF_FFFC wraps to 0.
    assign pc_plus4 = pc_q + 32'd4;

    always_comb begin
        pc_d       = pc_q;
        id_valid_d = id_valid_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        id_instr_d = id_instr_q;
        if (reset) begin
            pc_d       = RESET_PC;
            id_valid_d = 1'b0;
            id_pc_d    = 32'd0;
            id_pc4_d   = 32'd0;
            id_instr_d = BUBBLE_INSTR;
        end else if (redirect) begin
            // Low two bits are dropped; id_pc/id_pc4 keep their old values.
            pc_d       = redirect_pc & 32'hFFFF_FFFC;
            id_valid_d = 1'b0;
            id_instr_d = BUBBLE_INSTR;
        end else if (!stall) begin
            pc_d       = pc_plus4;
            id_valid_d = 1'b1;
            id_pc_d    = pc_q;
            id_pc4_d   = pc_plus4;
            id_instr_d = fetch_word;
        end
    end

    always_ff @(posedge CLK) begin
        pc_q       <= pc_d;
        id_valid_q <= id_valid_d;
        id_pc_q    <= id_pc_d;
        id_pc4_q   <= id_pc4_d;
        id_instr_q <= id_instr_d;
    end

    assign pc       = pc_q;
    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_pc4   = id_pc4_q;
    assign id_instr = id_instr_q;

    assign opcode = id_instr_q[OPCODE_MSB:OPCODE_LSB];
    assign rs     = id_instr_q[RS_MSB:RS_LSB];
    assign rt     = id_instr_q[RT_MSB:RT_LSB];
    assign rd     = id_instr_q[RD_MSB:RD_LSB];
    assign shamt  = id_instr_q[SHAMT_MSB:SHAMT_LSB];
    assign funct  = id_instr_q[FUNCT_MSB:FUNCT_LSB];
    assign imm    = id_instr_q[IMM_MSB:IMM_LSB];

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Bench for instr_fetch_stage: a reference model tracks PC and IF/ID, and
// every advancing edge pushes {pc, word} into exp_q, popped after the edge.
module tb_instr_fetch_stage;

    localparam logic [31:0] BUBBLE = 32'hFC00_0000;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = 8'd0;
    logic [31:0] imem_wdata = 32'd0;
    logic [31:0] pc, id_pc, id_pc4, id_instr;
    logic        id_valid;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model
    logic [31:0] m_mem [0:255];
    logic [31:0] m_pc;
    logic        m_id_valid;
    logic [31:0] m_id_pc, m_id_pc4, m_id_instr;
    logic [63:0] exp_q [$];

    instr_fetch_stage #(
        .IMEM_AW  (8),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_pc4      (id_pc4),
        .id_instr    (id_instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm         (imm)
    );

    // Clock
    always #5 CLK = ~CLK;

    // Driver: applies one cycle of stimulus, updates the model, waits for
    // the edge and samples 1 time unit later.
    task automatic drive(input logic st, input logic rdir, input logic [31:0] rpc,
                         input logic we, input logic [7:0] wa, input logic [31:0] wd,
                         output logic adv);
        stall = st; redirect = rdir; redirect_pc = rpc;
        imem_we = we; imem_waddr = wa; imem_wdata = wd;
        adv = 1'b0;
        if (rdir) begin
            m_pc = rpc & 32'hFFFF_FFFC;
            m_id_valid = 1'b0;
            m_id_instr = BUBBLE;
        end else if (!st) begin
            m_id_instr = m_mem[m_pc[9:2]];
            m_id_pc = m_pc;
            m_id_pc4 = m_pc + 32'd4;
            m_id_valid = 1'b1;
            exp_q.push_back({m_pc, m_id_instr});
            m_pc = m_pc + 32'd4;
            adv = 1'b1;
        end
        if (we) m_mem[wa] = wd;
        @(posedge CLK); #1;
        stall = 1'b0; redirect = 1'b0; imem_we = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
        m_mem[a] = d;
        @(posedge CLK); #1;
        imem_we = 1'b0;
    endtask

    task automatic model_reset();
        m_pc = 32'd0; m_id_valid = 1'b0; m_id_pc = 32'd0; m_id_pc4 = 32'd0;
        m_id_instr = BUBBLE;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge CLK); #1;
        model_reset();
        n_checks++; if (id_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got=%b exp=0", id_valid); end
        n_checks++; if (opcode !== 6'h3F) begin n_errors++; $display("FAIL reset_opcode got=%h exp=3f", opcode); end
        n_checks++; if (id_instr !== BUBBLE) begin n_errors++; $display("FAIL reset_instr got=%h exp=%h", id_instr, BUBBLE); end
        n_checks++; if (pc !== 32'd0) begin n_errors++; $display("FAIL reset_pc got=%h exp=0", pc); end
        n_checks++; if (id_pc !== 32'd0 || id_pc4 !== 32'd0) begin n_errors++; $display("FAIL reset_idpc got=%h/%h exp=0/0", id_pc, id_pc4); end
        // Program load under reset: whole memory, fixed words where the plan needs them.
        for (int i = 0; i < 256; i++) begin
            load_word(i[7:0], $urandom);
        end
        load_word(8'd0, 32'h8C01_0004);
        load_word(8'd1, 32'h0022_1820);
        load_word(8'd2, 32'hAC03_0008);
        load_word(8'd3, 32'h0000_0000);
        load_word(8'd5, 32'hDEAD_0005);
        load_word(8'd255, 32'h2000_00FF);
        n_checks++; if (id_valid !== 1'b0 || opcode !== 6'h3F) begin n_errors++; $display("FAIL reset_hold got=%b/%h exp=0/3f", id_valid, opcode); end
        reset = 1'b0;
    endtask

    task automatic test_sequential();
        logic adv;
        logic [63:0] e;
        logic [5:0] exp_op [0:1];
        exp_op[0] = 6'h23; exp_op[1] = 6'h00;
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
            e = exp_q.pop_front();
            n_checks++; if (id_valid !== 1'b1) begin n_errors++; $display("FAIL seq_valid[%0d] got=%b exp=1", i, id_valid); end
            n_checks++; if (opcode !== exp_op[i]) begin n_errors++; $display("FAIL seq_opcode[%0d] got=%h exp=%h", i, opcode, exp_op[i]); end
            n_checks++; if (id_instr !== e[31:0]) begin n_errors++; $display("FAIL seq_instr[%0d] got=%h exp=%h", i, id_instr, e[31:0]); end
            n_checks++; if (id_pc !== e[63:32] || id_pc !== 32'(i * 4)) begin n_errors++; $display("FAIL seq_idpc[%0d] got=%h exp=%h", i, id_pc, e[63:32]); end
            n_checks++; if (id_pc4 !== e[63:32] + 32'd4) begin n_errors++; $display("FAIL seq_idpc4[%0d] got=%h exp=%h", i, id_pc4, e[63:32] + 32'd4); end
        end
        n_checks++; if (rs !== 5'd1 || rt !== 5'd2 || rd !== 5'd3 || funct !== 6'h20 || shamt !== 5'd0 || imm !== 16'h1820) begin
            n_errors++; $display("FAIL seq_fields got=%h %h %h %h %h %h", rs, rt, rd, shamt, funct, imm); end
    endtask

    task automatic test_stall();
        logic adv;
        logic [63:0] e;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
            n_checks++; if (pc !== 32'd8) begin n_errors++; $display("FAIL stall_pc[%0d] got=%h exp=8", i, pc); end
            n_checks++; if (id_instr !== 32'h0022_1820 || id_valid !== 1'b1 || id_pc !== 32'd4) begin
                n_errors++; $display("FAIL stall_hold[%0d] got=%h/%b/%h exp=00221820/1/4", i, id_instr, id_valid, id_pc); end
        end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_pc !== 32'd8 || id_pc !== e[63:32]) begin n_errors++; $display("FAIL stall_resume_pc got=%h exp=8", id_pc); end
        n_checks++; if (opcode !== 6'h2B || id_instr !== e[31:0]) begin n_errors++; $display("FAIL stall_resume_instr got=%h exp=%h", id_instr, e[31:0]); end
    endtask

    task automatic test_redirect();
        logic adv;
        logic [63:0] e;
        drive(1'b1, 1'b1, 32'h0000_0007, 1'b0, 8'd0, 32'd0, adv);
        n_checks++; if (pc !== 32'd4) begin n_errors++; $display("FAIL redir_pc got=%h exp=4", pc); end
        n_checks++; if (id_valid !== 1'b0 || opcode !== 6'h3F || id_instr !== BUBBLE) begin
            n_errors++; $display("FAIL redir_bubble got=%b/%h exp=0/fc000000", id_valid, id_instr); end
        n_checks++; if (id_pc !== 32'd8 || id_pc4 !== 32'd12) begin n_errors++; $display("FAIL redir_idpc_kept got=%h/%h exp=8/c", id_pc, id_pc4); end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_pc !== 32'd4 || id_instr !== 32'h0022_1820 || id_instr !== e[31:0]) begin
            n_errors++; $display("FAIL redir_target got=%h/%h exp=4/00221820", id_pc, id_instr); end
    endtask

    task automatic test_wrap();
        logic adv;
        logic [63:0] e;
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 8'd0, 32'd0, adv);
        n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_errors++; $display("FAIL wrap_redir_pc got=%h exp=fffffffc", pc); end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_instr !== 32'h2000_00FF || id_instr !== e[31:0]) begin n_errors++; $display("FAIL wrap_word255 got=%h exp=200000ff", id_instr); end
        n_checks++; if (pc !== 32'd0 || id_pc4 !== 32'd0 || id_pc !== 32'hFFFF_FFFC) begin
            n_errors++; $display("FAIL wrap_pc got=%h/%h/%h exp=0/0/fffffffc", pc, id_pc4, id_pc); end
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_instr !== 32'h8C01_0004 || id_pc !== e[63:32]) begin n_errors++; $display("FAIL wrap_word0 got=%h exp=8c010004", id_instr); end
    endtask

    task automatic test_read_before_write();
        logic adv;
        logic [63:0] e;
        drive(1'b0, 1'b1, 32'd20, 1'b0, 8'd0, 32'd0, adv);
        drive(1'b0, 1'b0, 32'd0, 1'b1, 8'd5, 32'h1234_5678, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_instr !== 32'hDEAD_0005 || id_instr !== e[31:0]) begin n_errors++; $display("FAIL rbw_old got=%h exp=dead0005", id_instr); end
        drive(1'b0, 1'b1, 32'd20, 1'b0, 8'd0, 32'd0, adv);
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_instr !== 32'h1234_5678 || id_instr !== e[31:0]) begin n_errors++; $display("FAIL rbw_new got=%h exp=12345678", id_instr); end
    endtask

    task automatic test_back_to_back();
        logic adv;
        logic [63:0] e;
        logic st, rdir;
        logic [31:0] rpc;
        for (int i = 0; i < 200; i++) begin
            st = ($urandom_range(0, 3) == 0);
            rdir = ($urandom_range(0, 7) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1023));
            drive(st, rdir, rpc, 1'b0, 8'd0, 32'd0, adv);
            if (adv) begin
                e = exp_q.pop_front();
                n_checks++; if (id_valid !== 1'b1 || id_pc !== e[63:32] || id_instr !== e[31:0] || id_pc4 !== e[63:32] + 32'd4) begin
                    n_errors++; $display("FAIL b2b_fetch[%0d] got=%h@%h exp=%h@%h", i, id_instr, id_pc, e[31:0], e[63:32]); end
            end else begin
                n_checks++; if (id_valid !== m_id_valid || id_instr !== m_id_instr || id_pc !== m_id_pc) begin
                    n_errors++; $display("FAIL b2b_hold[%0d] got=%b/%h/%h exp=%b/%h/%h", i, id_valid, id_instr, id_pc, m_id_valid, m_id_instr, m_id_pc); end
            end
            n_checks++; if (pc !== m_pc) begin n_errors++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, pc, m_pc); end
        end
    endtask

    task automatic test_reset_mid();
        logic adv;
        logic [63:0] e;
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0040; reset = 1'b1;
        @(posedge CLK); #1;
        model_reset();
        n_checks++; if (pc !== 32'd0 || id_valid !== 1'b0 || id_pc !== 32'd0 || id_pc4 !== 32'd0 || id_instr !== BUBBLE) begin
            n_errors++; $display("FAIL midreset_state got=%h/%b/%h/%h/%h exp=0/0/0/0/fc000000", pc, id_valid, id_pc, id_pc4, id_instr); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0, adv);
        e = exp_q.pop_front();
        n_checks++; if (id_instr !== 32'h8C01_0004 || id_instr !== e[31:0] || id_valid !== 1'b1) begin
            n_errors++; $display("FAIL midreset_mem got=%h exp=8c010004", id_instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_wrap();
        test_read_before_write();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
